rps_match_ctrl: RTL and testbench
=================================

Name: rps_match_ctrl

Overview:
- Parametrised two-player rock-paper-scissors match controller.
- Paces rounds with a countdown derived from an internal tick divider, then captures both players' one-hot punches on a single capture cycle.
- Judges each round, keeps running scores, and ends the match at a configurable winning score.
- Drives the display layer (8x8 matrix and seven-segment decoders sit downstream and consume the registered outputs).

Parameters:
- CLK_DIV, 25000: CLK cycles per tick; must be >= 2.
- COUNTDOWN_TICKS, 3: ticks in the pre-capture countdown; range 1..15.
- SHOW_TICKS, 4: ticks the round result is held before the next round.
- WIN_SCORE, 3: round wins that end the match; must be >= 1.
- SCORE_W, $clog2(WIN_SCORE+1): score output width. Derived; do not override.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset, asynchronous, active-high. Clears all state.
- start  in  1  level; sampled every CLK edge in IDLE/DONE only.
- punch_1  in  3  player 1 punch, one-hot: bit0 scissors, bit1 stone, bit2 paper.
- punch_2  in  3  player 2 punch, same encoding.
- countdown  out  4  remaining countdown ticks; 0 outside COUNT.
- shown_1  out  3  player 1 punch captured this round.
- shown_2  out  3  player 2 punch captured this round.
- result  out  2  0 none, 1 player 1 wins, 2 player 2 wins, 3 tie.
- score_1  out  SCORE_W  player 1 round wins.
- score_2  out  SCORE_W  player 2 round wins.
- match_over  out  1  high in DONE.
- winner  out  2  0 none, 1 player 1, 2 player 2. Valid while match_over is high.
- busy  out  1  high in any state except IDLE and DONE.

Behaviour:
- Reset: all outputs 0, state IDLE, tick counter 0.
- Tick: one-CLK pulse every CLK_DIV cycles. Counter clears on every entry to COUNT and SHOW, so the first tick arrives exactly CLK_DIV cycles after entry.
- IDLE: start=1 -> COUNT on the next edge.
  - Loads countdown=COUNTDOWN_TICKS.
  - Clears scores, result, shown_1, shown_2, winner.
- COUNT: each tick decrements countdown. A tick while countdown==1 -> CAPTURE with countdown=0.
- CAPTURE (1 cycle): shown_1<=punch_1 and shown_2<=punch_2, raw values -> JUDGE.
- JUDGE (1 cycle):
  - A punch is valid only if exactly one bit is set.
  - Invalid vs valid: the valid side wins. Both invalid: tie.
  - Both valid: stone beats scissors, scissors beats paper, paper beats stone. Equal punches: tie.
  - result is registered. The winner's score increments; a tie changes neither score.
  - -> SHOW.
- SHOW: result, shown_1 and shown_2 are held for SHOW_TICKS ticks. Then:
  - If score_1 or score_2 == WIN_SCORE -> DONE.
  - Otherwise -> COUNT, reloading countdown, clearing result to 0 and keeping scores.
- DONE: match_over=1 and winner set; scores, result and shown_1/shown_2 are held.
  - start=1 behaves exactly as start in IDLE.
- start is ignored in COUNT, CAPTURE, JUDGE and SHOW.
- Scores never exceed WIN_SCORE. Only one score can change per round.
- Round latency: CAPTURE edge to result valid is 1 cycle. The start edge to CAPTURE is COUNTDOWN_TICKS*CLK_DIV+1 cycles.
- RST mid-round: immediate return to IDLE with the reset values above. No partial score is retained.

Optional Feature:
- Macro EARLY_FOUL_EN.
- Defined:
  - In COUNT, on the tick that takes countdown from 1 to 0, any nonzero punch marks that player as fouled (foul flag, cleared on COUNT entry).
  - JUDGE treats a fouled player's punch as invalid, overriding normal judging.
  - Both fouled: tie.
  - Extra output foul out 2 (bit0 player 1, bit1 player 2), valid from JUDGE through SHOW, else 0.
- Undefined: punches are ignored outside CAPTURE; the foul output is absent.

Decomposition:
- Package rps_pkg:
  - Punch encoding constants (SCISSORS=3'b001, STONE=3'b010, PAPER=3'b100).
  - Result/winner encodings.
  - State enum (IDLE, COUNT, CAPTURE, JUDGE, SHOW, DONE).
  - A pure judge function (punch_a, punch_b) -> result.
- Sub-module tick_gen: parameter CLK_DIV; ports CLK, RST, clr, tick. It replaces the free-running divider with a clearable, single-cycle tick.

Test Plan (CLK_DIV=4, COUNTDOWN_TICKS=3, SHOW_TICKS=2, WIN_SCORE=2):
- Reset then start pulse -> countdown 3,2,1 at 4-cycle spacing; CAPTURE at cycle 13 after start edge.
- Round: punch_1=010 (stone), punch_2=001 (scissors) -> result=1, score_1=1, score_2=0. After 2 ticks, next countdown=3.
- Round: 100 vs 100 -> result=3, scores unchanged. Then 000 vs 100 -> result=2 (invalid forfeits); 011 vs 000 -> result=3.
- Player 1 wins two rounds -> DONE, match_over=1, winner=1, score_1=2. start -> scores 0, countdown 3.
- Assert RST during SHOW -> all outputs 0 within the same cycle, state IDLE. start mid-COUNT ignored (countdown sequence unperturbed).
- EARLY_FOUL_EN: punch_1=010 held at the 1->0 tick, punch_2 idle until CAPTURE then 001 -> foul=01, result=2.

Source files
------------

// File: rtl/rps_pkg.sv
// Shared encodings, FSM state type and round-judging helper for the
// rock-paper-scissors match controller.
package rps_pkg;

   // One-hot punch encodings
   localparam logic [2:0] SCISSORS = 3'b001;
   localparam logic [2:0] STONE    = 3'b010;
   localparam logic [2:0] PAPER    = 3'b100;

   // Round result encodings
   localparam logic [1:0] RES_NONE = 2'd0;
   localparam logic [1:0] RES_P1   = 2'd1;
   localparam logic [1:0] RES_P2   = 2'd2;
   localparam logic [1:0] RES_TIE  = 2'd3;

   // Match winner encodings
   localparam logic [1:0] WIN_NONE = 2'd0;
   localparam logic [1:0] WIN_P1   = 2'd1;
   localparam logic [1:0] WIN_P2   = 2'd2;

   typedef enum logic [2:0] {
      IDLE,
      COUNT,
      CAPTURE,
      JUDGE,
      SHOW,
      DONE
   } state_t;

   // A punch counts only when it is exactly one of the three legal codes
   function automatic logic punch_valid(input logic [2:0] p);
      return (p == SCISSORS) || (p == STONE) || (p == PAPER);
   endfunction

   // Decide a round; an invalid punch forfeits against a valid one
   function automatic logic [1:0] judge(input logic [2:0] punch_a,
                                        input logic [2:0] punch_b);
      logic va;
      logic vb;
      logic a_beats;
      va      = punch_valid(punch_a);
      vb      = punch_valid(punch_b);
      a_beats = ((punch_a == STONE)    && (punch_b == SCISSORS)) ||
                ((punch_a == SCISSORS) && (punch_b == PAPER))    ||
                ((punch_a == PAPER)    && (punch_b == STONE));
      if (!va && !vb)
         return RES_TIE;
      else if (!va)
         return RES_P2;
      else if (!vb)
         return RES_P1;
      else if (punch_a == punch_b)
         return RES_TIE;
      else if (a_beats)
         return RES_P1;
      else
         return RES_P2;
   endfunction

endpackage

// File: rtl/rps_match_ctrl_tick_gen.sv
// Clearable tick divider: one-cycle tick every CLK_DIV cycles, counted
// from the last clear, so the first tick lands exactly CLK_DIV cycles
// after the clearing edge.
module tick_gen #(
   parameter int CLK_DIV = 25000
) (
   input  logic CLK,
   input  logic RST,
   input  logic clr,
   output logic tick
);

   localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

   logic [CNT_W-1:0] cnt;

   assign tick = (cnt == CNT_W'(CLK_DIV - 1));

   // Divider counter; clear wins so a state entry restarts the period
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         cnt <= '0;
      else if (clr || tick)
         cnt <= '0;
      else
         cnt <= cnt + CNT_W'(1);
   end

endmodule

// File: rtl/rps_match_ctrl.sv
// Two-player rock-paper-scissors match controller: paced countdown,
// single-cycle punch capture, judging, scoring and match termination.
// Optional build macro EARLY_FOUL_EN: punching on the final countdown
// tick fouls that player and adds the 'foul' output.
module rps_match_ctrl
   import rps_pkg::*;
#(
   parameter int CLK_DIV         = 25000,
   parameter int COUNTDOWN_TICKS = 3,
   parameter int SHOW_TICKS      = 4,
   parameter int WIN_SCORE       = 3,
   parameter int SCORE_W         = $clog2(WIN_SCORE + 1)
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               start,
   input  logic [2:0]         punch_1,
   input  logic [2:0]         punch_2,
   output logic [3:0]         countdown,
   output logic [2:0]         shown_1,
   output logic [2:0]         shown_2,
   output logic [1:0]         result,
   output logic [SCORE_W-1:0] score_1,
   output logic [SCORE_W-1:0] score_2,
   output logic               match_over,
   output logic [1:0]         winner,
   output logic               busy
`ifdef EARLY_FOUL_EN
   ,output logic [1:0]        foul
`endif
);

   localparam int SHOW_W = (SHOW_TICKS > 1) ? $clog2(SHOW_TICKS + 1) : 1;
   localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_SCORE);

   state_t             state, state_nxt;
   logic [3:0]         countdown_nxt;
   logic [2:0]         shown_1_nxt, shown_2_nxt;
   logic [1:0]         result_nxt, winner_nxt;
   logic [SCORE_W-1:0] score_1_nxt, score_2_nxt;
   logic [SHOW_W-1:0]  show_cnt, show_cnt_nxt;
   logic [2:0]         judge_1, judge_2;
   logic [1:0]         res_now;
   logic               tick, tick_clr;
`ifdef EARLY_FOUL_EN
   logic [1:0]         foul_r, foul_nxt;
`endif

   tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
      .CLK  (CLK),
      .RST  (RST),
      .clr  (tick_clr),
      .tick (tick)
   );

   assign match_over = (state == DONE);
   assign busy       = (state != IDLE) && (state != DONE);

`ifdef EARLY_FOUL_EN
   assign foul    = ((state == JUDGE) || (state == SHOW)) ? foul_r : 2'b00;
   assign judge_1 = foul_r[0] ? 3'b000 : shown_1;
   assign judge_2 = foul_r[1] ? 3'b000 : shown_2;
`else
   assign judge_1 = shown_1;
   assign judge_2 = shown_2;
`endif

   assign res_now = judge(judge_1, judge_2);

   // State and datapath registers; reset returns everything to IDLE/zero
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         countdown <= '0;
         shown_1   <= '0;
         shown_2   <= '0;
         result    <= RES_NONE;
         score_1   <= '0;
         score_2   <= '0;
         winner    <= WIN_NONE;
         show_cnt  <= '0;
`ifdef EARLY_FOUL_EN
         foul_r    <= '0;
`endif
      end else begin
         state     <= state_nxt;
         countdown <= countdown_nxt;
         shown_1   <= shown_1_nxt;
         shown_2   <= shown_2_nxt;
         result    <= result_nxt;
         score_1   <= score_1_nxt;
         score_2   <= score_2_nxt;
         winner    <= winner_nxt;
         show_cnt  <= show_cnt_nxt;
`ifdef EARLY_FOUL_EN
         foul_r    <= foul_nxt;
`endif
      end
   end

   // Next-state and next-register logic; tick_clr fires on each entry to COUNT/SHOW
   always_comb begin
      state_nxt     = state;
      countdown_nxt = countdown;
      shown_1_nxt   = shown_1;
      shown_2_nxt   = shown_2;
      result_nxt    = result;
      score_1_nxt   = score_1;
      score_2_nxt   = score_2;
      winner_nxt    = winner;
      show_cnt_nxt  = show_cnt;
      tick_clr      = 1'b0;
`ifdef EARLY_FOUL_EN
      foul_nxt      = foul_r;
`endif
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt     = COUNT;
               countdown_nxt = 4'(COUNTDOWN_TICKS);
               shown_1_nxt   = '0;
               shown_2_nxt   = '0;
               result_nxt    = RES_NONE;
               score_1_nxt   = '0;
               score_2_nxt   = '0;
               winner_nxt    = WIN_NONE;
               tick_clr      = 1'b1;
`ifdef EARLY_FOUL_EN
               foul_nxt      = 2'b00;
`endif
            end
         end
         COUNT: begin
            if (tick) begin
               if (countdown == 4'd1) begin
                  state_nxt     = CAPTURE;
                  countdown_nxt = '0;
`ifdef EARLY_FOUL_EN
                  foul_nxt      = {punch_2 != 3'b000, punch_1 != 3'b000};
`endif
               end else begin
                  countdown_nxt = countdown - 4'd1;
               end
            end
         end
         CAPTURE: begin
            shown_1_nxt = punch_1;
            shown_2_nxt = punch_2;
            state_nxt   = JUDGE;
         end
         JUDGE: begin
            result_nxt = res_now;
            if ((res_now == RES_P1) && (score_1 != WIN_VAL))
               score_1_nxt = score_1 + SCORE_W'(1);
            if ((res_now == RES_P2) && (score_2 != WIN_VAL))
               score_2_nxt = score_2 + SCORE_W'(1);
            show_cnt_nxt = SHOW_W'(SHOW_TICKS);
            state_nxt    = SHOW;
            tick_clr     = 1'b1;
         end
         SHOW: begin
            if (tick) begin
               if (show_cnt == SHOW_W'(1)) begin
                  if ((score_1 == WIN_VAL) || (score_2 == WIN_VAL)) begin
                     state_nxt  = DONE;
                     winner_nxt = (score_1 == WIN_VAL) ? WIN_P1 : WIN_P2;
                  end else begin
                     state_nxt     = COUNT;
                     countdown_nxt = 4'(COUNTDOWN_TICKS);
                     result_nxt    = RES_NONE;
                     tick_clr      = 1'b1;
`ifdef EARLY_FOUL_EN
                     foul_nxt      = 2'b00;
`endif
                  end
               end else begin
                  show_cnt_nxt = show_cnt - SHOW_W'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_rps_match_ctrl.sv
// Self-checking bench for rps_match_ctrl: directed rounds plus a random
// match, each compared against a rule-level model of the game.
module tb_rps_match_ctrl;

   localparam int CLK_DIV = 4;
   localparam int CD      = 3;
   localparam int SHOWT   = 2;
   localparam int WIN     = 2;
   localparam int SW      = $clog2(WIN + 1);

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          start = 1'b0;
   logic [2:0]    punch_1 = 3'b000;
   logic [2:0]    punch_2 = 3'b000;
   logic [3:0]    countdown;
   logic [2:0]    shown_1, shown_2;
   logic [1:0]    result;
   logic [SW-1:0] score_1, score_2;
   logic          match_over;
   logic [1:0]    winner;
   logic          busy;
`ifdef EARLY_FOUL_EN
   logic [1:0]    foul;
`endif

   int compared = 0;
   int mismatched = 0;
   int s1 = 0;
   int s2 = 0;

   rps_match_ctrl #(
      .CLK_DIV(CLK_DIV), .COUNTDOWN_TICKS(CD), .SHOW_TICKS(SHOWT), .WIN_SCORE(WIN)
   ) dut (
      .CLK(CLK), .RST(RST), .start(start), .punch_1(punch_1), .punch_2(punch_2),
      .countdown(countdown), .shown_1(shown_1), .shown_2(shown_2), .result(result),
      .score_1(score_1), .score_2(score_2), .match_over(match_over),
      .winner(winner), .busy(busy)
`ifdef EARLY_FOUL_EN
      , .foul(foul)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Rule model: rank scissors=0, stone=1, paper=2; x beats y when x = y+1 mod 3
   function automatic logic [1:0] ref_result(input logic [2:0] a, input logic [2:0] b);
      int ia, ib;
      bit va, vb;
      va = ($countones(a) == 1);
      vb = ($countones(b) == 1);
      if (!va && !vb) return 2'd3;
      if (!va) return 2'd2;
      if (!vb) return 2'd1;
      ia = a[0] ? 0 : (a[1] ? 1 : 2);
      ib = b[0] ? 0 : (b[1] ? 1 : 2);
      if (ia == ib) return 2'd3;
      if (ia == (ib + 1) % 3) return 2'd1;
      return 2'd2;
   endfunction

   task automatic start_match();
      start = 1'b1;
      step();
      start = 1'b0;
      s1 = 0;
      s2 = 0;
      chk("start_countdown", countdown, CD);
      chk("start_score1", score_1, 0);
      chk("start_score2", score_2, 0);
      chk("start_result", result, 0);
      chk("start_shown1", shown_1, 0);
      chk("start_winner", winner, 0);
      chk("start_match_over", match_over, 0);
   endtask

   // Plays one round from COUNT entry through the end of SHOW
   task automatic do_round(input logic [2:0] p1, input logic [2:0] p2,
                           input bit poke_start, input bit early_p1);
      logic [1:0] exp_res;
      bit f1;
      for (int k = 0; k < CD; k++) begin
         chk("countdown_seq", countdown, CD - k);
         chk("busy_count", busy, 1);
         for (int c = 0; c < CLK_DIV; c++) begin
`ifdef EARLY_FOUL_EN
            punch_1 = early_p1 ? p1 : 3'b000;
            punch_2 = 3'b000;
`else
            punch_1 = 3'($urandom_range(0, 7));
            punch_2 = 3'($urandom_range(0, 7));
`endif
            start = (poke_start && k == 1);
            step();
         end
      end
      start = 1'b0;
      chk("countdown_zero", countdown, 0);
      punch_1 = p1;
      punch_2 = p2;
      step();
      chk("shown_1", shown_1, p1);
      chk("shown_2", shown_2, p2);
      punch_1 = 3'($urandom_range(0, 7));
      punch_2 = 3'($urandom_range(0, 7));
      step();
`ifdef EARLY_FOUL_EN
      f1 = early_p1 && (p1 != 3'b000);
`else
      f1 = 1'b0;
`endif
      exp_res = ref_result(f1 ? 3'b000 : p1, p2);
      if (exp_res == 2'd1 && s1 < WIN) s1++;
      if (exp_res == 2'd2 && s2 < WIN) s2++;
      chk("result", result, exp_res);
      chk("score_1", score_1, s1);
      chk("score_2", score_2, s2);
`ifdef EARLY_FOUL_EN
      chk("foul", foul, {1'b0, f1});
`endif
      repeat (SHOWT * CLK_DIV - 1) step();
      chk("result_held", result, exp_res);
      step();
      if (s1 == WIN || s2 == WIN) begin
         chk("match_over", match_over, 1);
         chk("winner", winner, (s1 == WIN) ? 1 : 2);
         chk("busy_done", busy, 0);
         chk("result_done_held", result, exp_res);
      end else begin
         chk("next_countdown", countdown, CD);
         chk("next_result_clear", result, 0);
         chk("not_over", match_over, 0);
      end
   endtask

   initial begin
      // Reset state
      repeat (2) step();
      chk("rst_countdown", countdown, 0);
      chk("rst_result", result, 0);
      chk("rst_busy", busy, 0);
      chk("rst_match_over", match_over, 0);
      chk("rst_winner", winner, 0);
      RST = 1'b0;
      step();
      chk("idle_busy", busy, 0);

      // Directed match, start poked mid-COUNT in the first round
      start_match();
      do_round(3'b010, 3'b001, 1'b1, 1'b0);
      do_round(3'b100, 3'b100, 1'b0, 1'b0);
      do_round(3'b000, 3'b100, 1'b0, 1'b0);
      do_round(3'b011, 3'b000, 1'b0, 1'b0);
      do_round(3'b100, 3'b010, 1'b0, 1'b0);
      chk("final_score_1", score_1, 2);
      repeat (3) step();
      chk("done_stays", match_over, 1);

      // Restart from DONE, then a random match
      start_match();
      for (int n = 0; n < 40 && s1 < WIN && s2 < WIN; n++)
         do_round(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b0, 1'b0);
      chk("random_match_over", match_over, 1);

`ifdef EARLY_FOUL_EN
      start_match();
      do_round(3'b010, 3'b001, 1'b0, 1'b1);
`endif

      // Reset in the middle of SHOW
      start_match();
      repeat (CD * CLK_DIV) step();
      punch_1 = 3'b010;
      punch_2 = 3'b001;
      repeat (2) step();
      chk("pre_rst_result", result, 1);
      repeat (3) step();
      RST = 1'b1;
      #1;
      chk("midrst_result", result, 0);
      chk("midrst_score1", score_1, 0);
      chk("midrst_shown1", shown_1, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_countdown", countdown, 0);
      step();
      RST = 1'b0;
      repeat (CLK_DIV * 2) step();
      chk("post_rst_idle", busy, 0);
      chk("post_rst_countdown", countdown, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
